// File: rtl/aes_enc_round_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, GF(2^8) helpers and the S-box.
package aes_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_enc_round_ctrl_if.sv
// Plaintext/key input and ciphertext output handshakes of the AES round controller.
interface aes_enc_round_ctrl_if;
    import aes_pkg::*;

    logic             iValid;
    logic             oReady;
    logic [BLK_W-1:0] iData;
    logic [BLK_W-1:0] iKey;
    logic             oValid;
    logic             iReady;
    logic [BLK_W-1:0] oData;
    logic             oBusy;

    modport slave (
        input  iValid, iData, iKey, iReady,
        output oReady, oValid, oData, oBusy
    );

    modport master (
        output iValid, iData, iKey, iReady,
        input  oReady, oValid, oData, oBusy
    );

endinterface

// File: rtl/aes_enc_round_ctrl_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] key_i,
    input  logic [7:0]       rcon_i,
    output logic [BLK_W-1:0] key_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, tmp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign tmp = sub ^ {rcon_i, 24'h000000};

    assign n0 = w0 ^ tmp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_enc_round_ctrl_xform.sv
// Combinational AES round transforms. Byte i of a block sits at bits [127-8i -: 8], i = 4*col + row.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    output logic [BLK_W-1:0] data_o
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end
endmodule

module aes_shift_rows
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    output logic [BLK_W-1:0] data_o
);
    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_o[127-8*(4*c+r) -: 8] = data_i[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end
endmodule

module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    output logic [BLK_W-1:0] data_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = data_i[127-32*c -: 8];
        assign a1 = data_i[119-32*c -: 8];
        assign a2 = data_i[111-32*c -: 8];
        assign a3 = data_i[103-32*c -: 8];
        assign data_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign data_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign data_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign data_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock over a shared datapath, round keys derived on the fly.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    aes_enc_round_ctrl_if.slave  bus
);
    if (NR != 10) begin : g_nr_check
        $error("aes_enc_round_ctrl: only NR=10 (AES-128) is supported");
    end

    state_e           fsm_q, fsm_d;
    logic [BLK_W-1:0] blk_q;
    logic [BLK_W-1:0] key_q;
    logic [BLK_W-1:0] out_q;
    logic [3:0]       rnd_q;

    logic [7:0]       rcon;
    logic [BLK_W-1:0] key_nxt, sb, sr, mc, blk_nxt;
    logic             load, step, last;

    always_comb begin
        rcon = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (rnd_q == 4'(i)) rcon = RCON[i];
        end
    end

    aes_key_step    u_key_step (.key_i(key_q), .rcon_i(rcon), .key_o(key_nxt));
    aes_sub_bytes   u_sub      (.data_i(blk_q), .data_o(sb));
    aes_shift_rows  u_shift    (.data_i(sb),    .data_o(sr));
    aes_mix_columns u_mix      (.data_i(sr),    .data_o(mc));

    // The final round skips MixColumns.
    assign last    = (rnd_q == 4'(NR));
    assign blk_nxt = (last ? sr : mc) ^ key_nxt;

    always_comb begin
        fsm_d = fsm_q;
        load  = 1'b0;
        step  = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (bus.iValid) begin
                    load  = 1'b1;
                    fsm_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                step = 1'b1;
                if (last) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.iReady) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            fsm_q <= ST_IDLE;
            blk_q <= '0;
            key_q <= '0;
            out_q <= '0;
            rnd_q <= 4'd0;
        end else begin
            fsm_q <= fsm_d;
            if (load) begin
                blk_q <= bus.iData ^ bus.iKey;
                key_q <= bus.iKey;
                rnd_q <= 4'd1;
            end else if (step) begin
                blk_q <= blk_nxt;
                key_q <= key_nxt;
                rnd_q <= rnd_q + 4'd1;
                if (last) out_q <= blk_nxt;
            end
        end
    end

    assign bus.oReady = (fsm_q == ST_IDLE);
    assign bus.oBusy  = (fsm_q == ST_ROUND);
    assign bus.oValid = (fsm_q == ST_DONE);
    assign bus.oData  = out_q;

endmodule
